// File: rtl/riscv_csr_pkg.sv
`default_nettype none
// =============================================================================
// riscv_csr_pkg: shared CSR instruction encodings and requester state type
// Revision: 1.0
// =============================================================================
package riscv_csr_pkg;

   localparam logic [6:0] SYSTEM_OPCODE = 7'b1110011;

   localparam logic [2:0] F3_CSRRW  = 3'b001;
   localparam logic [2:0] F3_CSRRS  = 3'b010;
   localparam logic [2:0] F3_CSRRC  = 3'b011;
   localparam logic [2:0] F3_CSRRWI = 3'b101;
   localparam logic [2:0] F3_CSRRSI = 3'b110;
   localparam logic [2:0] F3_CSRRCI = 3'b111;

   typedef enum logic [1:0] {
      REQ_IDLE = 2'd0,
      REQ_BUS  = 2'd1,
      REQ_RESP = 2'd2
   } req_state_e;

   function automatic logic is_csr_funct3(input logic [2:0] f3);
      return (f3 == F3_CSRRW)  || (f3 == F3_CSRRS)  || (f3 == F3_CSRRC) ||
             (f3 == F3_CSRRWI) || (f3 == F3_CSRRSI) || (f3 == F3_CSRRCI);
   endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_csrbus_if.sv
`default_nettype none
// =============================================================================
// riscv_csrbus_if: single-outstanding CSR access bus between core and register block
// Revision: 1.0
// =============================================================================
interface riscv_csrbus_if #(
   parameter int XLEN = 32
) ();
   logic            valid;
   logic [11:0]     csr;
   logic [2:0]      funct3;
   logic [4:0]      rs1;
   logic [XLEN-1:0] rs1_value;
   logic            ready;
   logic [XLEN-1:0] rd_value;
   logic            error;

   modport master (
      output valid, csr, funct3, rs1, rs1_value,
      input  ready, rd_value, error
   );

   modport slave (
      input  valid, csr, funct3, rs1, rs1_value,
      output ready, rd_value, error
   );
endinterface
`default_nettype wire

// File: rtl/riscv_csr_requester.sv
`default_nettype none
// =============================================================================
// riscv_csr_requester: turns one decoded CSR instruction into one CSR bus
// transaction and returns rd writeback data, with a bus-timeout watchdog.
// Revision: 1.0
// =============================================================================
module riscv_csr_requester
   import riscv_csr_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_inst_valid,
   output logic            o_inst_ready,
   input  logic [31:0]     i_inst,
   input  logic [XLEN-1:0] i_rs1_value,
   output logic            o_result_valid,
   input  logic            i_result_ready,
   output logic [4:0]      o_rd,
   output logic            o_rd_write,
   output logic [XLEN-1:0] o_rd_value,
   output logic            o_illegal,
   riscv_csrbus_if.master  csrbus_if
);

   localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
   localparam bit TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   req_state_e      state_q, state_d;
   logic [11:0]     csr_q, csr_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [4:0]      rs1_q, rs1_d;
   logic [XLEN-1:0] rs1_value_q, rs1_value_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] rd_value_q, rd_value_d;
   logic            illegal_q, illegal_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic       w_legal;
   logic       w_accept;
   logic       w_timeout;

   assign w_opcode  = i_inst[6:0];
   assign w_funct3  = i_inst[14:12];
   assign w_legal   = (w_opcode == SYSTEM_OPCODE) && is_csr_funct3(w_funct3);
   assign w_accept  = i_inst_valid && o_inst_ready;
   assign w_timeout = TO_EN && (cnt_q == TO_LAST);

   // A consumed result frees the slot in the same cycle, giving back-to-back accepts.
   assign o_inst_ready   = (state_q == REQ_IDLE) || ((state_q == REQ_RESP) && i_result_ready);
   assign o_result_valid = (state_q == REQ_RESP);
   assign o_rd           = rd_q;
   assign o_rd_value     = rd_value_q;
   assign o_illegal      = illegal_q;
   assign o_rd_write     = !illegal_q && (rd_q != 5'd0);

   assign csrbus_if.valid     = (state_q == REQ_BUS);
   assign csrbus_if.csr       = csr_q;
   assign csrbus_if.funct3    = funct3_q;
   assign csrbus_if.rs1       = rs1_q;
   assign csrbus_if.rs1_value = rs1_value_q;

   always_comb begin
      state_d     = state_q;
      csr_d       = csr_q;
      funct3_d    = funct3_q;
      rs1_d       = rs1_q;
      rs1_value_d = rs1_value_q;
      rd_d        = rd_q;
      rd_value_d  = rd_value_q;
      illegal_d   = illegal_q;
      cnt_d       = cnt_q;

      case (state_q)
         REQ_IDLE, REQ_RESP: begin
            if (w_accept) begin
               rd_d       = i_inst[11:7];
               rd_value_d = '0;
               if (w_legal) begin
                  csr_d       = i_inst[31:20];
                  funct3_d    = w_funct3;
                  rs1_d       = i_inst[19:15];
                  rs1_value_d = i_rs1_value;
                  illegal_d   = 1'b0;
                  cnt_d       = '0;
                  state_d     = REQ_BUS;
               end else begin
                  illegal_d = 1'b1;
                  state_d   = REQ_RESP;
               end
            end else if ((state_q == REQ_RESP) && i_result_ready) begin
               state_d = REQ_IDLE;
            end
         end
         REQ_BUS: begin
            // ready on the limit cycle still completes normally
            if (csrbus_if.ready) begin
               rd_value_d = csrbus_if.error ? '0 : csrbus_if.rd_value;
               illegal_d  = csrbus_if.error;
               state_d    = REQ_RESP;
            end else if (w_timeout) begin
               rd_value_d = '0;
               illegal_d  = 1'b1;
               state_d    = REQ_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = REQ_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= REQ_IDLE;
         csr_q       <= '0;
         funct3_q    <= '0;
         rs1_q       <= '0;
         rs1_value_q <= '0;
         rd_q        <= '0;
         rd_value_q  <= '0;
         illegal_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         csr_q       <= csr_d;
         funct3_q    <= funct3_d;
         rs1_q       <= rs1_d;
         rs1_value_q <= rs1_value_d;
         rd_q        <= rd_d;
         rd_value_q  <= rd_value_d;
         illegal_q   <= illegal_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_csr_requester.sv
`default_nettype none
// =============================================================================
// tb_riscv_csr_requester: directed scoreboard bench with a configurable CSR slave
// Revision: 1.0
// =============================================================================
module tb_riscv_csr_requester;
   import riscv_csr_pkg::*;

   localparam int XLEN = 32;
   localparam int TO   = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            inst_valid = 1'b0;
   logic            inst_ready;
   logic [31:0]     inst = '0;
   logic [XLEN-1:0] rs1_value = '0;
   logic            result_valid;
   logic            result_ready = 1'b1;
   logic [4:0]      rd;
   logic            rd_write;
   logic [XLEN-1:0] rd_value;
   logic            illegal;

   riscv_csrbus_if #(.XLEN(XLEN)) bus ();

   riscv_csr_requester #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_inst_valid   (inst_valid),
      .o_inst_ready   (inst_ready),
      .i_inst         (inst),
      .i_rs1_value    (rs1_value),
      .o_result_valid (result_valid),
      .i_result_ready (result_ready),
      .o_rd           (rd),
      .o_rd_write     (rd_write),
      .o_rd_value     (rd_value),
      .o_illegal      (illegal),
      .csrbus_if      (bus)
   );

   always #5 clk = ~clk;

   // CSR slave: ready after wait_cfg wait states, or never
   int              wait_cfg = 0;
   logic            never_rdy = 1'b0;
   logic [XLEN-1:0] slv_rdata = '0;
   logic            slv_err = 1'b0;
   int              bus_cnt = 0;

   always @(posedge clk) begin
      if (bus.valid && !bus.ready) bus_cnt <= bus_cnt + 1;
      else                         bus_cnt <= 0;
   end
   assign bus.ready    = bus.valid && !never_rdy && (bus_cnt == wait_cfg);
   assign bus.rd_value = slv_rdata;
   assign bus.error    = slv_err;

   // bus monitor: valid-high cycles and request-field changes inside one transaction
   int        valid_cycles = 0;
   int        unstable = 0;
   logic      prev_valid = 1'b0;
   logic [51:0] snap = '0;
   always @(negedge clk) begin
      if (bus.valid) begin
         if (!prev_valid) snap <= {bus.csr, bus.funct3, bus.rs1, bus.rs1_value};
         else if ({bus.csr, bus.funct3, bus.rs1, bus.rs1_value} != snap) unstable <= unstable + 1;
         valid_cycles <= valid_cycles + 1;
      end
      prev_valid <= bus.valid;
   end

   typedef struct {
      logic [4:0]      rd;
      logic            rd_write;
      logic [XLEN-1:0] rd_value;
      logic            illegal;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass = 0;
   int base_v;
   int base_u;

   function automatic logic [31:0] mk(input logic [11:0] csr, input logic [4:0] r1,
                                      input logic [2:0] f3, input logic [4:0] rdi,
                                      input logic [6:0] opc);
      return {csr, r1, f3, rdi, opc};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic push(input logic [4:0] r, input logic w, input logic [XLEN-1:0] v,
                       input logic ill);
      exp_t e;
      e.rd = r; e.rd_write = w; e.rd_value = v; e.illegal = ill;
      exp_q.push_back(e);
   endtask

   task automatic check_front(input string tag);
      check({tag, " rd"},       rd,       exp_q[0].rd);
      check({tag, " rd_write"}, rd_write, exp_q[0].rd_write);
      check({tag, " rd_value"}, rd_value, exp_q[0].rd_value);
      check({tag, " illegal"},  illegal,  exp_q[0].illegal);
   endtask

   task automatic issue(input logic [31:0] w, input logic [XLEN-1:0] v);
      inst = w; rs1_value = v; inst_valid = 1'b1;
      @(posedge clk); #1;
      inst_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // exp_k counts negedges from now to the first one showing o_result_valid
   task automatic wait_result(input string tag, input int exp_k);
      int lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (result_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
      check({tag, " latency"}, lat, exp_k);
      if (lat != 0 && exp_q.size() > 0) begin
         check_front(tag);
         void'(exp_q.pop_front());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst result_valid", result_valid, 1'b0);
      check("rst bus valid",    bus.valid,    1'b0);
      check("rst rd",           rd,           5'd0);
      check("rst rd_value",     rd_value,     '0);
      check("rst illegal",      illegal,      1'b0);
      check("rst rd_write",     rd_write,     1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post-rst inst_ready", inst_ready, 1'b1);
      step();

      // CSRRW, zero-wait slave
      push(5'd5, 1'b1, 32'h1800, 1'b0);
      wait_cfg = 0; slv_rdata = 32'h1800; slv_err = 1'b0;
      base_v = valid_cycles;
      issue(mk(12'h300, 5'd1, F3_CSRRW, 5'd5, SYSTEM_OPCODE), 32'hDEADBEEF);
      @(negedge clk);
      check("csrrw bus valid",     bus.valid,     1'b1);
      check("csrrw bus csr",       bus.csr,       12'h300);
      check("csrrw bus funct3",    bus.funct3,    3'b001);
      check("csrrw bus rs1",       bus.rs1,       5'd1);
      check("csrrw bus rs1_value", bus.rs1_value, 32'hDEADBEEF);
      check("csrrw result early",  result_valid,  1'b0);
      wait_result("csrrw", 1);
      check("csrrw valid cycles", valid_cycles - base_v, 1);
      step();

      // CSRRS rd=0 with 3 wait states; ready lands on the timeout limit cycle
      push(5'd0, 1'b0, 32'h1234, 1'b0);
      wait_cfg = 3; slv_rdata = 32'h1234;
      base_v = valid_cycles; base_u = unstable;
      issue(mk(12'h341, 5'd0, F3_CSRRS, 5'd0, SYSTEM_OPCODE), 32'h0);
      wait_result("csrrs_wait", 5);
      check("csrrs valid dropped",   bus.valid, 1'b0);
      check("csrrs valid cycles",    valid_cycles - base_v, 4);
      check("csrrs request stable",  unstable - base_u, 0);
      step();

      // illegal funct3 and non-SYSTEM opcode: no bus access
      wait_cfg = 0;
      push(5'd7, 1'b0, '0, 1'b1);
      base_v = valid_cycles;
      issue(mk(12'h300, 5'd1, 3'b100, 5'd7, SYSTEM_OPCODE), 32'h1111);
      wait_result("illegal_f3", 1);
      step();
      push(5'd9, 1'b0, '0, 1'b1);
      issue(mk(12'h300, 5'd1, F3_CSRRW, 5'd9, 7'h33), 32'h2222);
      wait_result("illegal_op", 1);
      check("illegal no bus valid", valid_cycles - base_v, 0);
      step();

      // slave error
      push(5'd6, 1'b0, '0, 1'b1);
      slv_rdata = 32'h55; slv_err = 1'b1;
      issue(mk(12'h7C0, 5'd2, F3_CSRRC, 5'd6, SYSTEM_OPCODE), 32'hF0);
      wait_result("bus_error", 2);
      slv_err = 1'b0;
      step();

      // timeout: slave never ready
      push(5'd3, 1'b0, '0, 1'b1);
      never_rdy = 1'b1;
      base_v = valid_cycles;
      issue(mk(12'hBAD, 5'd4, F3_CSRRW, 5'd3, SYSTEM_OPCODE), 32'h77);
      wait_result("timeout", 5);
      check("timeout valid cycles", valid_cycles - base_v, TO);
      never_rdy = 1'b0;
      step();

      // back-to-back CSRRWI with 3 cycles of result backpressure
      push(5'd8, 1'b1, 32'hA, 1'b0);
      push(5'd9, 1'b1, 32'hB, 1'b0);
      wait_cfg = 0; slv_rdata = 32'hA; result_ready = 1'b0;
      issue(mk(12'h340, 5'd5, F3_CSRRWI, 5'd8, SYSTEM_OPCODE), 32'h0);
      inst = mk(12'h305, 5'd7, F3_CSRRWI, 5'd9, SYSTEM_OPCODE);
      inst_valid = 1'b1;
      @(negedge clk);
      check("b2b bus phase inst_ready", inst_ready, 1'b0);
      step();
      slv_rdata = 32'hB;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("b2b held result_valid", result_valid, 1'b1);
         check("b2b held inst_ready",   inst_ready,   1'b0);
         check_front("b2b held");
         step();
      end
      result_ready = 1'b1;
      @(negedge clk);
      check("b2b accept inst_ready", inst_ready, 1'b1);
      check_front("b2b first");
      void'(exp_q.pop_front());
      step();
      inst_valid = 1'b0;
      wait_result("b2b second", 2);
      step();

      // reset asserted mid-BUS
      never_rdy = 1'b1;
      issue(mk(12'h300, 5'd1, F3_CSRRW, 5'd4, SYSTEM_OPCODE), 32'h99);
      @(negedge clk);
      check("midrst bus valid before", bus.valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst bus valid async",  bus.valid,    1'b0);
      check("midrst result_valid",     result_valid, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      never_rdy = 1'b0;
      @(negedge clk);
      check("midrst idle inst_ready",  inst_ready,   1'b1);
      check("midrst idle result",      result_valid, 1'b0);

      check("scoreboard empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
